// File: rtl/dmem_port_ctrl_if.sv
// Bus bundle between the two requesters, the port controller and the word-only data memory.
// Each port is a request/acknowledge handshake: the requester raises pN_req with its command
// fields stable and holds them until it sees the one-cycle pN_ack pulse; pN_err and pN_rdata
// are valid only while pN_ack is high. A request with pN_req low carries no meaning.
interface dmem_port_ctrl_if #(
  parameter int W = 32
);
  logic         p0_req;
  logic         p0_we;
  logic [1:0]   p0_size;
  logic         p0_unsigned;
  logic [W-1:0] p0_addr;
  logic [W-1:0] p0_wdata;
  logic         p0_ack;
  logic         p0_err;
  logic [W-1:0] p0_rdata;

  logic         p1_req;
  logic         p1_we;
  logic [1:0]   p1_size;
  logic         p1_unsigned;
  logic [W-1:0] p1_addr;
  logic [W-1:0] p1_wdata;
  logic         p1_ack;
  logic         p1_err;
  logic [W-1:0] p1_rdata;

  logic         mem_read_en;
  logic [W-1:0] mem_read_addr;
  logic [W-1:0] mem_read_data;
  logic         mem_write_en;
  logic [W-1:0] mem_write_addr;
  logic [W-1:0] mem_write_data;

  modport slave (
    input  p0_req, p0_we, p0_size, p0_unsigned, p0_addr, p0_wdata,
    output p0_ack, p0_err, p0_rdata,
    input  p1_req, p1_we, p1_size, p1_unsigned, p1_addr, p1_wdata,
    output p1_ack, p1_err, p1_rdata,
    output mem_read_en, mem_read_addr, mem_write_en, mem_write_addr, mem_write_data,
    input  mem_read_data
  );

  modport master (
    output p0_req, p0_we, p0_size, p0_unsigned, p0_addr, p0_wdata,
    input  p0_ack, p0_err, p0_rdata,
    output p1_req, p1_we, p1_size, p1_unsigned, p1_addr, p1_wdata,
    input  p1_ack, p1_err, p1_rdata,
    input  mem_read_en, mem_read_addr, mem_write_en, mem_write_addr, mem_write_data,
    output mem_read_data
  );
endinterface

// File: rtl/dmem_port_ctrl.sv
// Two-port arbiter and sequencer for a word-only data memory: sub-word load extraction,
// read-modify-write for SB/SH, misalignment rejection. Macro DMEM_ARB_FIXED_PRIO_EN selects fixed port-0 priority.
module dmem_port_ctrl #(
  parameter int W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  dmem_port_ctrl_if.slave      bus,
  output logic [1:0]           dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic         ack0_q, ack0_d, err0_q, err0_d;
  logic         ack1_q, ack1_d, err1_q, err1_d;
  logic [W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic         we_q, we_d, uns_q, uns_d, id_q, id_d;
  logic [1:0]   size_q, size_d;
  logic [W-1:0] addr_q, addr_d, wdata_q, wdata_d, merge_q, merge_d;

  logic         elig0, elig1, grant, win_id;
  logic         sel_we, sel_uns;
  logic [1:0]   sel_size;
  logic [W-1:0] sel_addr, sel_wdata;
  logic [W-1:0] load_val, merged, shifted;
  logic [15:0]  half_sel;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    return (size == 2'b11) || (size == 2'b01 && a[0]) || (size == 2'b10 && a != 2'b00);
  endfunction

`ifdef DMEM_ARB_FIXED_PRIO_EN
  // Port 1 also yields during port 0's ack cycle, so a held port-0 request keeps the memory.
  always_comb begin
    elig0  = bus.p0_req && !ack0_q;
    elig1  = bus.p1_req && !ack1_q && !ack0_q;
    grant  = elig0 || elig1;
    win_id = !elig0;
  end
`else
  logic rr_q, rr_d;

  always_comb begin
    elig0  = bus.p0_req && !ack0_q;
    elig1  = bus.p1_req && !ack1_q;
    grant  = elig0 || elig1;
    if (elig0 && elig1) win_id = !rr_q;
    else                win_id = elig1;
  end

  always_comb begin
    rr_d = rr_q;
    if (state_q == S_IDLE && grant) rr_d = win_id;
  end

  always_ff @(posedge clk) begin
    if (!rst) rr_q <= 1'b1;
    else      rr_q <= rr_d;
  end
`endif

  always_comb begin
    sel_we    = win_id ? bus.p1_we       : bus.p0_we;
    sel_size  = win_id ? bus.p1_size     : bus.p0_size;
    sel_uns   = win_id ? bus.p1_unsigned : bus.p0_unsigned;
    sel_addr  = win_id ? bus.p1_addr     : bus.p0_addr;
    sel_wdata = win_id ? bus.p1_wdata    : bus.p0_wdata;
  end

  // Little-endian lane select for loads and the byte/half splice for sub-word stores.
  always_comb begin
    shifted  = bus.mem_read_data >> {addr_q[1:0], 3'b000};
    half_sel = addr_q[1] ? bus.mem_read_data[31:16] : bus.mem_read_data[15:0];
    case (size_q)
      2'b00:   load_val = uns_q ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = uns_q ? {16'd0, half_sel}     : {{16{half_sel[15]}}, half_sel};
      default: load_val = bus.mem_read_data;
    endcase
    merged = bus.mem_read_data;
    if (size_q == 2'b00)      merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
    else if (size_q == 2'b01) merged[{addr_q[1], 4'b0000} +: 16]  = wdata_q[15:0];
  end

  always_comb begin
    state_d  = state_q;
    ack0_d   = 1'b0;
    err0_d   = 1'b0;
    ack1_d   = 1'b0;
    err1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    we_d     = we_q;
    size_d   = size_q;
    uns_d    = uns_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    id_d     = id_q;
    merge_d  = merge_q;
    case (state_q)
      S_IDLE: begin
        if (grant) begin
          we_d    = sel_we;
          size_d  = sel_size;
          uns_d   = sel_uns;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          id_d    = win_id;
          if (misaligned(sel_size, sel_addr[1:0])) begin
            if (win_id) begin
              ack1_d   = 1'b1;
              err1_d   = 1'b1;
              rdata1_d = '0;
            end else begin
              ack0_d   = 1'b1;
              err0_d   = 1'b1;
              rdata0_d = '0;
            end
          end else if (sel_we && sel_size == 2'b10) begin
            state_d = S_WR;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        if (we_q) begin
          merge_d = merged;
          state_d = S_WR;
        end else begin
          if (id_q) begin
            ack1_d   = 1'b1;
            rdata1_d = load_val;
          end else begin
            ack0_d   = 1'b1;
            rdata0_d = load_val;
          end
          state_d = S_IDLE;
        end
      end
      S_WR: begin
        if (id_q) ack1_d = 1'b1;
        else      ack0_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      ack0_q   <= 1'b0;
      err0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      we_q     <= 1'b0;
      size_q   <= 2'b00;
      uns_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      id_q     <= 1'b0;
      merge_q  <= '0;
    end else begin
      state_q  <= state_d;
      ack0_q   <= ack0_d;
      err0_q   <= err0_d;
      ack1_q   <= ack1_d;
      err1_q   <= err1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      we_q     <= we_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      id_q     <= id_d;
      merge_q  <= merge_d;
    end
  end

  // Memory strobes are pure state decodes, so they can never overlap and are low in IDLE.
  assign bus.mem_read_en    = (state_q == S_RD);
  assign bus.mem_write_en   = (state_q == S_WR);
  assign bus.mem_read_addr  = {addr_q[W-1:2], 2'b00};
  assign bus.mem_write_addr = {addr_q[W-1:2], 2'b00};
  assign bus.mem_write_data = (size_q == 2'b10) ? wdata_q : merge_q;

  assign bus.p0_ack   = ack0_q;
  assign bus.p0_err   = err0_q;
  assign bus.p0_rdata = rdata0_q;
  assign bus.p1_ack   = ack1_q;
  assign bus.p1_err   = err1_q;
  assign bus.p1_rdata = rdata1_q;

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dmem_port_ctrl.sv
// Directed bench for dmem_port_ctrl: word memory model, per-port request driver, expected-value queue.
module tb_dmem_port_ctrl;
  localparam int W = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  dmem_port_ctrl_if #(.W(W)) bus ();

  dmem_port_ctrl #(.W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  logic [W-1:0] mem [0:15];
  logic [W-1:0] last_wr_addr = '0;
  logic [W-1:0] last_wr_data = '0;
  int wr_cnt = 0, rd_cnt = 0, ack0_cnt = 0, ack1_cnt = 0, both_cnt = 0;

  assign bus.mem_read_data = mem[bus.mem_read_addr[5:2]];

  always @(posedge clk) begin
    if (bus.mem_write_en) begin
      mem[bus.mem_write_addr[5:2]] <= bus.mem_write_data;
      last_wr_addr <= bus.mem_write_addr;
      last_wr_data <= bus.mem_write_data;
      wr_cnt <= wr_cnt + 1;
    end
    if (bus.mem_read_en) rd_cnt <= rd_cnt + 1;
    if (bus.mem_read_en && bus.mem_write_en) both_cnt <= both_cnt + 1;
    if (bus.p0_ack) ack0_cnt <= ack0_cnt + 1;
    if (bus.p1_ack) ack1_cnt <= ack1_cnt + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic set_port(input int port, input logic req, input logic we, input logic [1:0] size,
                          input logic uns, input logic [W-1:0] addr, input logic [W-1:0] wdata);
    if (port == 0) begin
      bus.p0_req = req; bus.p0_we = we; bus.p0_size = size;
      bus.p0_unsigned = uns; bus.p0_addr = addr; bus.p0_wdata = wdata;
    end else begin
      bus.p1_req = req; bus.p1_we = we; bus.p1_size = size;
      bus.p1_unsigned = uns; bus.p1_addr = addr; bus.p1_wdata = wdata;
    end
  endtask

  // One transaction; req stays high through the ack cycle to expose any re-grant.
  task automatic do_req(input string tag, input int port, input logic we, input logic [1:0] size,
                        input logic uns, input logic [W-1:0] addr, input logic [W-1:0] wdata,
                        input int exp_lat, input logic exp_err, input logic [W-1:0] exp_rdata);
    int   lat;
    logic got, ack, err;
    logic [W-1:0] rdata;
    lat = 0; got = 1'b0; err = 1'b0; rdata = '0;
    if (!we || exp_err) exp_q.push_back(exp_rdata);
    set_port(port, 1'b1, we, size, uns, addr, wdata);
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      lat++;
      ack = (port == 0) ? bus.p0_ack : bus.p1_ack;
      if (ack) begin
        got   = 1'b1;
        err   = (port == 0) ? bus.p0_err : bus.p1_err;
        rdata = (port == 0) ? bus.p0_rdata : bus.p1_rdata;
      end
    end
    check({tag, "_ack_seen"}, W'(got), W'(1));
    check({tag, "_latency"}, W'(lat), W'(exp_lat));
    check({tag, "_err"}, W'(err), W'(exp_err));
    if (!we || exp_err) check({tag, "_rdata"}, rdata, exp_q.pop_front());
    @(posedge clk); #1;
    ack = (port == 0) ? bus.p0_ack : bus.p1_ack;
    check({tag, "_ack_pulse"}, W'(ack), W'(0));
    check({tag, "_no_regrant"}, W'(dbg_state), W'(0));
    set_port(port, 1'b0, 1'b0, 2'b00, 1'b0, '0, '0);
  endtask

  initial begin
    int wr0, rd0, a1;
    int order[$];
    int p0_n, p1_n;

    set_port(0, 1'b0, 1'b0, 2'b00, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, 2'b00, 1'b0, '0, '0);
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[0] = 32'h11223344;
    mem[1] = 32'h8899AABB;
    mem[3] = 32'hCAFEF00D;

    repeat (3) @(posedge clk);
    #1;
    check("rst_p0_ack",   W'(bus.p0_ack), W'(0));
    check("rst_p0_err",   W'(bus.p0_err), W'(0));
    check("rst_p0_rdata", bus.p0_rdata, '0);
    check("rst_p1_ack",   W'(bus.p1_ack), W'(0));
    check("rst_p1_rdata", bus.p1_rdata, '0);
    check("rst_rd_en",    W'(bus.mem_read_en), W'(0));
    check("rst_wr_en",    W'(bus.mem_write_en), W'(0));
    check("rst_state",    W'(dbg_state), W'(0));
    rst = 1'b1;
    @(posedge clk); #1;

    // Both ports hold load requests continuously.
    set_port(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10010004, '0);
    set_port(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10010000, '0);
`ifdef DMEM_ARB_FIXED_PRIO_EN
    p0_n = 0; p1_n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.p0_ack) begin
        p0_n++;
        check("arb_p0_rdata", bus.p0_rdata, 32'h8899AABB);
      end
      if (bus.p1_ack) p1_n++;
    end
    check("arb_fixed_p1_starved", W'(p1_n), W'(0));
    check("arb_fixed_p0_served", W'(p0_n >= 4), W'(1));
`else
    for (int i = 0; i < 40 && order.size() < 4; i++) begin
      @(posedge clk); #1;
      check("arb_no_dual_ack", W'(bus.p0_ack && bus.p1_ack), W'(0));
      if (bus.p0_ack) begin
        order.push_back(0);
        check("arb_p0_rdata", bus.p0_rdata, 32'h8899AABB);
      end
      if (bus.p1_ack) begin
        order.push_back(1);
        check("arb_p1_rdata", bus.p1_rdata, 32'h11223344);
      end
    end
    check("arb_grants", W'(order.size()), W'(4));
    while (order.size() < 4) order.push_back(-1);
    check("arb_order0", W'(order[0]), W'(0));
    check("arb_order1", W'(order[1]), W'(1));
    check("arb_order2", W'(order[2]), W'(0));
    check("arb_order3", W'(order[3]), W'(1));
`endif
    set_port(0, 1'b0, 1'b0, 2'b00, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, 2'b00, 1'b0, '0, '0);
    repeat (6) @(posedge clk);
    #1;

    do_req("lb",  0, 1'b0, 2'b00, 1'b0, 32'h10010005, '0, 2, 1'b0, 32'hFFFFFFAA);
    do_req("lbu", 0, 1'b0, 2'b00, 1'b1, 32'h10010005, '0, 2, 1'b0, 32'h000000AA);
    do_req("lh",  0, 1'b0, 2'b01, 1'b0, 32'h10010006, '0, 2, 1'b0, 32'hFFFF8899);
    do_req("lhu", 0, 1'b0, 2'b01, 1'b1, 32'h10010006, '0, 2, 1'b0, 32'h00008899);

    wr0 = wr_cnt;
    do_req("sb", 0, 1'b1, 2'b00, 1'b0, 32'h10010001, 32'h000000CC, 3, 1'b0, '0);
    check("sb_write_count", W'(wr_cnt - wr0), W'(1));
    check("sb_write_addr",  last_wr_addr, 32'h10010000);
    check("sb_write_data",  last_wr_data, 32'h1122CC44);
    check("sb_mem_word",    mem[0], 32'h1122CC44);

    wr0 = wr_cnt; rd0 = rd_cnt;
    do_req("misaligned_lw", 0, 1'b0, 2'b10, 1'b0, 32'h10010002, '0, 1, 1'b1, '0);
    check("misaligned_no_read",  W'(rd_cnt - rd0), W'(0));
    check("misaligned_no_write", W'(wr_cnt - wr0), W'(0));

    a1 = ack1_cnt; wr0 = wr_cnt;
    do_req("p1_sw", 1, 1'b1, 2'b10, 1'b0, 32'h10010008, 32'hDEADBEEF, 2, 1'b0, '0);
    check("p1_sw_write_count", W'(wr_cnt - wr0), W'(1));
    do_req("p1_lw", 1, 1'b0, 2'b10, 1'b0, 32'h10010008, '0, 2, 1'b0, 32'hDEADBEEF);
    check("p1_ack_count", W'(ack1_cnt - a1), W'(2));

    // Reset lands while a p1 SH sits in its read cycle.
    a1 = ack1_cnt; wr0 = wr_cnt;
    set_port(1, 1'b1, 1'b1, 2'b01, 1'b0, 32'h1001000E, 32'h00001234);
    @(posedge clk); #1;
    check("rst_mid_in_rd", W'(dbg_state), W'(1));
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    set_port(1, 1'b0, 1'b0, 2'b00, 1'b0, '0, '0);
    check("rst_mid_idle", W'(dbg_state), W'(0));
    repeat (3) @(posedge clk);
    #1;
    check("rst_mid_no_write", W'(wr_cnt - wr0), W'(0));
    check("rst_mid_no_ack",   W'(ack1_cnt - a1), W'(0));
    check("rst_mid_mem",      mem[3], 32'hCAFEF00D);
    check("rst_mid_rdata",    bus.p1_rdata, '0);
    do_req("post_rst_lw", 1, 1'b0, 2'b10, 1'b0, 32'h1001000C, '0, 2, 1'b0, 32'hCAFEF00D);

    check("never_rd_and_wr", W'(both_cnt), W'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
